e10_mgmt_arb: RTL and testbench

- Sequences and shares the 10GE MAC management (Avalon-MM CSR) buses of all E10 ports among several requesters, e.g. host indirect CSR path (PR-mgmt registers) and an on-chip statistics poller.
- Round-robin grant; one transaction in flight; per-port read/write strobes; waitrequest timeout protection.
- Sits between the E2E control CSR block and the per-port E10 MAC instances.

---
 rtl/e10_mgmt_pkg.sv | 14 +
 rtl/e10_mgmt_rr_arb.sv | 26 ++
 rtl/e10_mgmt_arb.sv | 141 ++++++++++++++
 tb/tb_e10_mgmt_arb.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/e10_mgmt_pkg.sv
// e10_mgmt_pkg: shared types and constants for the E10 management bus arbiter
package e10_mgmt_pkg;
   localparam int MGMT_PORT_W = 2;
   localparam int MGMT_ADDR_W = 16;
   localparam int MGMT_DATA_W = 32;
   localparam logic [31:0] MGMT_ERR_DATA = 32'hDEAD_BEEF;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} t_mgmt_state;
   typedef struct packed {
      logic                   write;
      logic [MGMT_PORT_W-1:0] port;
      logic [MGMT_ADDR_W-1:0] addr;
      logic [MGMT_DATA_W-1:0] wdata;
   } t_mgmt_req;
endpackage

// File: rtl/e10_mgmt_rr_arb.sv
// e10_mgmt_rr_arb: round-robin arbiter; priority starts just after the last granted index
module e10_mgmt_rr_arb #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   index
);
   logic [IDX_W-1:0] last;
   // scan from lowest to highest priority so the nearest requester after last wins
   always_comb begin
      index = '0;
      for (int k = NUM_REQ; k >= 1; k--)
         if (req[(int'(last) + k) % NUM_REQ]) index = IDX_W'((int'(last) + k) % NUM_REQ);
      grant = |req ? NUM_REQ'(1) << index : '0;
   end
   // pointer starts at the top index so requester 0 is favoured out of reset
   always_ff @(posedge clk) begin
      if (reset) last <= IDX_W'(NUM_REQ - 1);
      else if (advance) last <= index;
   end
endmodule

// File: rtl/e10_mgmt_arb.sv
// e10_mgmt_arb: shares the per-port E10 MAC CSR buses among requesters, one transaction at a time.
// Optional E10_MGMT_ARB_STATS_EN adds saturating txn_count / timeout_count outputs.
module e10_mgmt_arb import e10_mgmt_pkg::*; #(
   parameter int NUM_REQ        = 2,
   parameter int NUM_PORTS      = 4,
   parameter int ADDR_W         = MGMT_ADDR_W,
   parameter int DATA_W         = MGMT_DATA_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*2-1:0]        req_port,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_err,
   output logic [NUM_PORTS-1:0]        mac_read,
   output logic [NUM_PORTS-1:0]        mac_write,
   output logic [ADDR_W-1:0]           mac_address,
   output logic [DATA_W-1:0]           mac_writedata,
   input  logic [NUM_PORTS*DATA_W-1:0] mac_readdata,
   input  logic [NUM_PORTS-1:0]        mac_waitrequest,
   output logic                        busy
`ifdef E10_MGMT_ARB_STATS_EN
   ,
   output logic [31:0]                 txn_count,
   output logic [15:0]                 timeout_count
`endif
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   t_mgmt_state state, state_nxt;
   t_mgmt_req req_q;
   logic [NUM_REQ-1:0] gnt, owner;
   logic [IDX_W-1:0] gnt_idx;
   logic [DATA_W-1:0] data_q, rdata_sel;
   logic [CNT_W-1:0] tmo_cnt;
   logic err_q, fire, on_bus, port_ok, wait_sel, tmo_hit, done, fail;

   e10_mgmt_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid),
      .advance (fire),
      .grant   (gnt),
      .index   (gnt_idx)
   );

   // decode the latched target port; an out-of-range port never matches, so it sees no bus
   always_comb begin
      wait_sel = 1'b0;
      rdata_sel = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (req_q.port == MGMT_PORT_W'(p)) begin
            wait_sel = mac_waitrequest[p];
            rdata_sel = mac_readdata[p*DATA_W +: DATA_W];
         end
      port_ok = int'(req_q.port) < NUM_PORTS;
      on_bus = state == ISSUE || state == WAIT;
      tmo_hit = on_bus && port_ok && wait_sel && tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
      done = on_bus && (!port_ok || !wait_sel || tmo_hit);
      fail = !port_ok || tmo_hit;
      fire = state == IDLE && |req_valid && !reset;
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end

   // next state: ISSUE already samples waitrequest so a zero-wait access answers at grant+2;
   // an invalid port also passes through ISSUE (without strobes) so its latency matches
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        state_nxt = fire ? ISSUE : IDLE;
         ISSUE, WAIT: state_nxt = done ? RESP : WAIT;
         default:     state_nxt = IDLE;
      endcase
   end

   // request latch, owner, timeout counter and response capture
   always_ff @(posedge clk) begin
      if (reset) begin
         req_q <= '0;
         owner <= '0;
         data_q <= '0;
         err_q <= 1'b0;
         tmo_cnt <= '0;
      end else begin
         if (fire) begin
            req_q.write <= req_write[gnt_idx];
            req_q.port <= req_port[gnt_idx*2 +: 2];
            req_q.addr <= MGMT_ADDR_W'(req_addr[gnt_idx*ADDR_W +: ADDR_W]);
            req_q.wdata <= MGMT_DATA_W'(req_wdata[gnt_idx*DATA_W +: DATA_W]);
            owner <= gnt;
         end
         tmo_cnt <= (on_bus && wait_sel) ? tmo_cnt + 1'b1 : '0;
         if (done) begin
            err_q <= fail;
            data_q <= fail ? DATA_W'(MGMT_ERR_DATA) : (req_q.write ? '0 : rdata_sel);
         end
      end
   end

   // outputs: grant pulse, response pulse and the single active per-port strobe
   always_comb begin
      req_ready = fire ? gnt : '0;
      rsp_valid = state == RESP ? owner : '0;
      rsp_data = state == RESP ? data_q : '0;
      rsp_err = state == RESP && err_q;
      busy = state != IDLE;
      mac_read = '0;
      mac_write = '0;
      for (int p = 0; p < NUM_PORTS; p++)
         if (on_bus && req_q.port == MGMT_PORT_W'(p)) begin
            mac_read[p] = !req_q.write;
            mac_write[p] = req_q.write;
         end
      mac_address = on_bus && port_ok ? ADDR_W'(req_q.addr) : '0;
      mac_writedata = on_bus && port_ok && req_q.write ? DATA_W'(req_q.wdata) : '0;
   end

`ifdef E10_MGMT_ARB_STATS_EN
   // saturating completion and timeout counters
   always_ff @(posedge clk) begin
      if (reset) begin
         txn_count <= '0;
         timeout_count <= '0;
      end else begin
         if (state == RESP && txn_count != '1) txn_count <= txn_count + 1'b1;
         if (tmo_hit && timeout_count != '1) timeout_count <= timeout_count + 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_e10_mgmt_arb.sv
// tb_e10_mgmt_arb: scoreboard bench for e10_mgmt_arb (main instance plus a 3-port instance)
module tb_e10_mgmt_arb;
   localparam int NR = 2, NP = 4, AW = 16, DW = 32, TMO = 16;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;
   logic [NR-1:0] req_valid = '0, req_write = '0, req_ready, rsp_valid;
   logic [NR*2-1:0] req_port = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_wdata = '0;
   logic [DW-1:0] rsp_data, mac_writedata;
   logic rsp_err, busy;
   logic [NP-1:0] mac_read, mac_write, mac_waitrequest = '0;
   logic [AW-1:0] mac_address;
   logic [NP*DW-1:0] mac_readdata = '0;
   logic [NR-1:0] r3_valid = '0, r3_ready, r3_rsp;
   logic [DW-1:0] r3_data, m3_wd;
   logic r3_err, r3_busy;
   logic [2:0] m3_read, m3_write, m3_wait = '0;
   logic [AW-1:0] m3_addr;
   logic [3*DW-1:0] m3_rd = '0;
`ifdef E10_MGMT_ARB_STATS_EN
   logic [31:0] txn_count, txn3;
   logic [15:0] timeout_count, tmo3;
`endif

   e10_mgmt_arb #(.NUM_REQ(NR), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_port(req_port), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .mac_read(mac_read), .mac_write(mac_write),
      .mac_address(mac_address), .mac_writedata(mac_writedata), .mac_readdata(mac_readdata),
      .mac_waitrequest(mac_waitrequest), .busy(busy)
`ifdef E10_MGMT_ARB_STATS_EN
      , .txn_count(txn_count), .timeout_count(timeout_count)
`endif
   );

   e10_mgmt_arb #(.NUM_REQ(NR), .NUM_PORTS(3), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut3 (
      .clk(clk), .reset(reset), .req_valid(r3_valid), .req_ready(r3_ready), .req_write(req_write),
      .req_port(req_port), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(r3_rsp),
      .rsp_data(r3_data), .rsp_err(r3_err), .mac_read(m3_read), .mac_write(m3_write),
      .mac_address(m3_addr), .mac_writedata(m3_wd), .mac_readdata(m3_rd),
      .mac_waitrequest(m3_wait), .busy(r3_busy)
`ifdef E10_MGMT_ARB_STATS_EN
      , .txn_count(txn3), .timeout_count(tmo3)
`endif
   );

   int n_chk = 0, n_pass = 0, cyc = 0, last = NR - 1;
   typedef struct {int idx; logic [31:0] data; logic err;} t_exp;
   t_exp sb[$];
   t_exp e_cur;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // scoreboard: every response is compared against the oldest expected entry
   always @(negedge clk) begin
      if (|{mac_read, mac_write}) check("strobe_onehot", $countones({mac_read, mac_write}), 1);
      if (rsp_valid != '0) begin
         if (sb.size() == 0) check("unexpected_rsp", rsp_valid, 0);
         else begin
            e_cur = sb.pop_front();
            check("rsp_owner", rsp_valid, 2'b01 << e_cur.idx);
            check("rsp_data", rsp_data, e_cur.data);
            check("rsp_err", rsp_err, e_cur.err);
         end
      end
   end

   task automatic issue(input int r, input logic wr, input logic [1:0] port, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee, input bit push);
      int n = 0;
      req_write[r] = wr;
      req_port[r*2 +: 2] = port;
      req_addr[r*AW +: AW] = addr;
      req_wdata[r*DW +: DW] = wd;
      req_valid[r] = 1'b1;
      #1;
      while (!req_ready[r] && n < 50) begin
         @(negedge clk); #1; n++;
      end
      check("grant_seen", req_ready, 2'b01 << r);
      if (push) sb.push_back('{r, ed, ee});
      last = r;
      @(negedge clk);
      req_valid[r] = 1'b0;
      req_write[r] = ~wr;
      req_port[r*2 +: 2] = ~port;
      req_addr[r*AW +: AW] = ~addr;
      req_wdata[r*DW +: DW] = ~wd;
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin
         @(negedge clk); #1; n++;
      end
      check("idle_timeout", {busy, sb.size() != 0}, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_ready", req_ready, 0);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
      check("rst_strobes", {mac_read, mac_write}, 0);
      check("rst_bus", {mac_address, mac_writedata}, 0);
      check("rst_busy", busy, 0);
   endtask

   initial begin
      int cnt, n, exp, gprev;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs();
      reset = 1'b0;
      @(negedge clk); #1;
      // zero-wait write to port 2
      issue(0, 1'b1, 2'd2, 16'h3C0D, 32'd150, 32'd0, 1'b0, 1'b1);
      check("t1_strobe", {mac_read, mac_write}, {4'b0000, 4'b0100});
      check("t1_addr", mac_address, 16'h3C0D);
      check("t1_wdata", mac_writedata, 32'd150);
      @(negedge clk); #1;
      check("t1_strobe_drop", {mac_read, mac_write}, 0);
      check("t1_rsp_n2", {rsp_valid, rsp_err}, {2'b01, 1'b0});
      wait_idle();
      // read with five waitrequest cycles
      mac_waitrequest[1] = 1'b1;
      mac_readdata[1*DW +: DW] = 32'h0000_000A;
      issue(1, 1'b0, 2'd1, 16'h1C02, 32'd0, 32'h0000_000A, 1'b0, 1'b1);
      check("t2_addr", mac_address, 16'h1C02);
      cnt = 0;
      while (mac_read == 4'b0010 && cnt < 40) begin
         cnt++;
         if (cnt == 6) mac_waitrequest[1] = 1'b0;
         @(negedge clk); #1;
      end
      check("t2_hold", cnt, 6);
      wait_idle();
      // stuck waitrequest on port 3 -> timeout
      mac_waitrequest[3] = 1'b1;
      issue(0, 1'b0, 2'd3, 16'h0300, 32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
      cnt = 0;
      while (mac_read == 4'b1000 && cnt < 100) begin
         cnt++;
         @(negedge clk); #1;
      end
      check("t3_hold", cnt, TMO);
      mac_waitrequest[3] = 1'b0;
      wait_idle();
`ifdef E10_MGMT_ARB_STATS_EN
      check("t3_tmo_count", timeout_count, 1);
      check("t3_txn_count", txn_count, 3);
`endif
      // reset while in WAIT discards the transaction
      mac_waitrequest[2] = 1'b1;
      issue(0, 1'b0, 2'd2, 16'h2000, 32'd0, 32'd0, 1'b0, 1'b0);
      @(negedge clk); #1;
      check("t4_in_wait", mac_read, 4'b0100);
      reset = 1'b1;
      req_write = 2'b10;
      req_port = {2'd1, 2'd0};
      req_addr = {16'h0020, 16'h0010};
      req_wdata = {32'h0000_0055, 32'd0};
      mac_readdata[0 +: DW] = 32'h1234_5678;
      req_valid = 2'b11;
      @(negedge clk); #1;
      check_reset_outputs();
      @(negedge clk); #1;
      check("t4_no_rsp", rsp_valid, 0);
      mac_waitrequest[2] = 1'b0;
      reset = 1'b0;
      last = NR - 1;
      #1;
      // continuous load from both requesters alternates strictly
      gprev = 0;
      for (int t = 0; t < 4; t++) begin
         n = 0;
         while (req_ready == '0 && n < 20) begin
            @(negedge clk); #1; n++;
         end
         exp = (last + 1) % NR;
         check("rr_grant", req_ready, 2'b01 << exp);
         sb.push_back('{exp, exp == 0 ? 32'h1234_5678 : 32'd0, 1'b0});
         last = exp;
         if (t > 0) check("rr_spacing", cyc - gprev, 3);
         gprev = cyc;
         @(negedge clk); #1;
      end
      req_valid = '0;
      wait_idle();
`ifdef E10_MGMT_ARB_STATS_EN
      check("t4_stats", {txn_count, timeout_count}, {32'd4, 16'd0});
`endif
      // invalid port on a 3-port instance
      req_write[0] = 1'b0;
      req_port[1:0] = 2'd3;
      req_addr[AW-1:0] = 16'h0042;
      r3_valid = 2'b01;
      #1;
      n = 0;
      while (r3_ready == '0 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("t5_grant", r3_ready, 2'b01);
      @(negedge clk);
      r3_valid = '0;
      #1;
      check("t5_no_strobe", {m3_read, m3_write, r3_rsp}, 0);
      check("t5_busy", r3_busy, 1);
      @(negedge clk); #1;
      check("t5_rsp", {r3_rsp, r3_err, r3_data}, {2'b01, 1'b1, 32'hDEAD_BEEF});
      @(negedge clk); #1;
      check("t5_done", {r3_rsp, r3_busy}, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
